// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command sequencer: opcodes, sequencer states
// and default operand widths.
package gpu_pkg;

  localparam int WIDTH_DEFAULT   = 10;
  localparam int HEIGHT_DEFAULT  = 9;
  localparam int CHANNEL_DEFAULT = 8;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LINE   = 4'h1;
  localparam logic [3:0] OP_ARC    = 4'h2;
  localparam logic [3:0] OP_CIRCLE = 4'h3;
  localparam logic [3:0] OP_FILL   = 4'h4;
  localparam logic [3:0] OP_FLUSH  = 4'h5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/gpu_cmd_controller.sv
// Command sequencer: pops one command from the FWFT FIFO, latches its operands,
// runs the matching raster engine until it reports done, and issues frame flushes.
module gpu_cmd_controller
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = WIDTH_DEFAULT,
  parameter int HEIGHT_BITS  = HEIGHT_DEFAULT,
  parameter int CHANNEL_BITS = CHANNEL_DEFAULT
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]              oct_i,
  input  logic                    fifo_empty_i,
  input  logic                    finished_line_i,
  input  logic                    finished_fill_i,
  input  logic                    finished_arc_i,
  input  logic                    finished_circle_i,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [WIDTH_BITS-1:0]   x1_line_o,
  output logic [HEIGHT_BITS-1:0]  y1_line_o,
  output logic [WIDTH_BITS-1:0]   x2_line_o,
  output logic [HEIGHT_BITS-1:0]  y2_line_o,
  output logic                    run_line_o,
  output logic [WIDTH_BITS-1:0]   x1_fill_o,
  output logic [HEIGHT_BITS-1:0]  y1_fill_o,
  output logic [WIDTH_BITS-1:0]   x2_fill_o,
  output logic [HEIGHT_BITS-1:0]  y2_fill_o,
  output logic                    run_fill_o,
  output logic [WIDTH_BITS-1:0]   x1_arc_o,
  output logic [HEIGHT_BITS-1:0]  y1_arc_o,
  output logic [WIDTH_BITS-1:0]   rad_arc_o,
  output logic [2:0]              oct_arc_o,
  output logic                    run_arc_o,
  output logic [WIDTH_BITS-1:0]   x1_circle_o,
  output logic [HEIGHT_BITS-1:0]  y1_circle_o,
  output logic [WIDTH_BITS-1:0]   rad_circle_o,
  output logic                    run_circle_o,
  output logic                    pop_o,
  output logic                    flush_frame_o
);

  state_e                  state_q;
  logic [3:0]              opcode_q;
  logic [WIDTH_BITS-1:0]   x1_q, x2_q, rad_q;
  logic [HEIGHT_BITS-1:0]  y1_q, y2_q;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic [2:0]              oct_q;
  logic                    run_line_q, run_fill_q, run_arc_q, run_circle_q;
  logic                    flush_q;
  logic                    finished_sel;

  // Only the engine named by the latched opcode may end the RUN stay.
  always_comb begin
    finished_sel = 1'b0;
    case (opcode_q)
      OP_LINE:   finished_sel = finished_line_i;
      OP_FILL:   finished_sel = finished_fill_i;
      OP_ARC:    finished_sel = finished_arc_i;
      OP_CIRCLE: finished_sel = finished_circle_i;
      default:   finished_sel = 1'b0;
    endcase
  end

  // Reset is folded in so the read strobe is quiet the moment reset is applied.
  assign pop_o = !n_rst && (state_q == IDLE) && !fifo_empty_i;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      rad_q        <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      oct_q        <= '0;
      run_line_q   <= 1'b0;
      run_fill_q   <= 1'b0;
      run_arc_q    <= 1'b0;
      run_circle_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_i) begin
            opcode_q <= opcode_i;
            x1_q     <= x1_i;
            x2_q     <= x2_i;
            rad_q    <= rad_i;
            y1_q     <= y1_i;
            y2_q     <= y2_i;
            r_q      <= r_i;
            g_q      <= g_i;
            b_q      <= b_i;
            oct_q    <= oct_i;
            case (opcode_i)
              OP_LINE:   begin state_q <= RUN;   run_line_q   <= 1'b1; end
              OP_FILL:   begin state_q <= RUN;   run_fill_q   <= 1'b1; end
              OP_ARC:    begin state_q <= RUN;   run_arc_q    <= 1'b1; end
              OP_CIRCLE: begin state_q <= RUN;   run_circle_q <= 1'b1; end
              OP_FLUSH:  begin state_q <= FLUSH; flush_q      <= 1'b1; end
              default:   state_q <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (finished_sel) begin
            state_q      <= IDLE;
            run_line_q   <= 1'b0;
            run_fill_q   <= 1'b0;
            run_arc_q    <= 1'b0;
            run_circle_q <= 1'b0;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_o           = r_q;
  assign g_o           = g_q;
  assign b_o           = b_q;
  assign x1_line_o     = x1_q;
  assign y1_line_o     = y1_q;
  assign x2_line_o     = x2_q;
  assign y2_line_o     = y2_q;
  assign x1_fill_o     = x1_q;
  assign y1_fill_o     = y1_q;
  assign x2_fill_o     = x2_q;
  assign y2_fill_o     = y2_q;
  assign x1_arc_o      = x1_q;
  assign y1_arc_o      = y1_q;
  assign rad_arc_o     = rad_q;
  assign oct_arc_o     = oct_q;
  assign x1_circle_o   = x1_q;
  assign y1_circle_o   = y1_q;
  assign rad_circle_o  = rad_q;
  assign run_line_o    = run_line_q;
  assign run_fill_o    = run_fill_q;
  assign run_arc_o     = run_arc_q;
  assign run_circle_o  = run_circle_q;
  assign flush_frame_o = flush_q;

endmodule

// File: tb/tb_gpu_cmd_controller.sv
// Bench for gpu_cmd_controller: an emulated FWFT FIFO feeds directed and random
// commands; a transaction-level model predicts every output each cycle.
module tb_gpu_cmd_controller;

  localparam int W = 10;
  localparam int H = 9;
  localparam int C = 8;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] rad;
    logic [H-1:0] y1;
    logic [H-1:0] y2;
    logic [2:0]   oct;
    logic [C-1:0] r;
    logic [C-1:0] g;
    logic [C-1:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic [3:0] opcode_i;
  logic [W-1:0] x1_i, x2_i, rad_i;
  logic [H-1:0] y1_i, y2_i;
  logic [C-1:0] r_i, g_i, b_i;
  logic [2:0] oct_i;
  logic fifo_empty_i;
  logic finished_line_i, finished_fill_i, finished_arc_i, finished_circle_i;
  logic [C-1:0] r_o, g_o, b_o;
  logic [W-1:0] x1_line_o, x2_line_o, x1_fill_o, x2_fill_o, x1_arc_o, rad_arc_o, x1_circle_o, rad_circle_o;
  logic [H-1:0] y1_line_o, y2_line_o, y1_fill_o, y2_fill_o, y1_arc_o, y1_circle_o;
  logic [2:0] oct_arc_o;
  logic run_line_o, run_fill_o, run_arc_o, run_circle_o, pop_o, flush_frame_o;

  always #5 clk = ~clk;

  gpu_cmd_controller dut (
    .clk(clk), .n_rst(n_rst),
    .opcode_i(opcode_i), .x1_i(x1_i), .x2_i(x2_i), .rad_i(rad_i),
    .y1_i(y1_i), .y2_i(y2_i), .r_i(r_i), .g_i(g_i), .b_i(b_i), .oct_i(oct_i),
    .fifo_empty_i(fifo_empty_i),
    .finished_line_i(finished_line_i), .finished_fill_i(finished_fill_i),
    .finished_arc_i(finished_arc_i), .finished_circle_i(finished_circle_i),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .x1_line_o(x1_line_o), .y1_line_o(y1_line_o), .x2_line_o(x2_line_o), .y2_line_o(y2_line_o),
    .run_line_o(run_line_o),
    .x1_fill_o(x1_fill_o), .y1_fill_o(y1_fill_o), .x2_fill_o(x2_fill_o), .y2_fill_o(y2_fill_o),
    .run_fill_o(run_fill_o),
    .x1_arc_o(x1_arc_o), .y1_arc_o(y1_arc_o), .rad_arc_o(rad_arc_o), .oct_arc_o(oct_arc_o),
    .run_arc_o(run_arc_o),
    .x1_circle_o(x1_circle_o), .y1_circle_o(y1_circle_o), .rad_circle_o(rad_circle_o),
    .run_circle_o(run_circle_o),
    .pop_o(pop_o), .flush_frame_o(flush_frame_o)
  );

  cmd_t       fifo[$];
  cmd_t       junk;
  logic [3:0] fin = 4'b0000;   // {circle, arc, fill, line}
  bit         hide = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Model: last popped command, which engine is busy (-1 none), pending flush.
  cmd_t m_cmd = '0;
  int   m_eng = -1;
  bit   m_flush = 1'b0;
  bit   started = 1'b0;

  function automatic int eng_of(input logic [3:0] op);
    case (op)
      4'd1:    return 0;
      4'd4:    return 1;
      4'd2:    return 2;
      4'd3:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic cmd_t rand_cmd(input logic [3:0] op);
    cmd_t c;
    c.op  = op;
    c.x1  = W'($urandom);
    c.x2  = W'($urandom);
    c.rad = W'($urandom);
    c.y1  = H'($urandom);
    c.y2  = H'($urandom);
    c.oct = 3'($urandom);
    c.r   = C'($urandom);
    c.g   = C'($urandom);
    c.b   = C'($urandom);
    return c;
  endfunction

  function automatic logic [160:0] ops_of(input cmd_t c);
    return {c.r, c.g, c.b,
            c.x1, c.y1, c.x2, c.y2,
            c.x1, c.y1, c.x2, c.y2,
            c.x1, c.y1, c.rad, c.oct,
            c.x1, c.y1, c.rad};
  endfunction

  wire [160:0] dut_ops = {r_o, g_o, b_o,
                          x1_line_o, y1_line_o, x2_line_o, y2_line_o,
                          x1_fill_o, y1_fill_o, x2_fill_o, y2_fill_o,
                          x1_arc_o, y1_arc_o, rad_arc_o, oct_arc_o,
                          x1_circle_o, y1_circle_o, rad_circle_o};
  wire [3:0] dut_runs = {run_circle_o, run_arc_o, run_fill_o, run_line_o};

  task automatic drive_head();
    cmd_t c;
    if (fifo.size() > 0 && !hide) begin
      c = fifo[0];
      fifo_empty_i = 1'b0;
    end else begin
      c = junk;
      fifo_empty_i = 1'b1;
    end
    opcode_i = c.op; x1_i = c.x1; x2_i = c.x2; rad_i = c.rad;
    y1_i = c.y1; y2_i = c.y2; oct_i = c.oct; r_i = c.r; g_i = c.g; b_i = c.b;
    {finished_circle_i, finished_arc_i, finished_fill_i, finished_line_i} = fin;
  endtask

  // Advance one clock; new inputs settle at +1, caller checks at +4.
  task automatic step(input logic [3:0] f, input bit h);
    @(posedge clk);
    #1;
    fin = f;
    hide = h;
    drive_head();
    #3;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] fv;
    started = 1'b1;
    fv = {finished_circle_i, finished_arc_i, finished_fill_i, finished_line_i};
    if (n_rst) begin
      m_cmd = '0;
      m_eng = -1;
      m_flush = 1'b0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (m_eng >= 0) begin
      if (fv[m_eng]) m_eng = -1;
    end else if (!fifo_empty_i) begin
      m_cmd = fifo.pop_front();
      m_eng = eng_of(m_cmd.op);
      m_flush = (m_cmd.op == 4'd5);
    end
  end

  always @(negedge clk) begin
    logic         e_pop;
    logic [3:0]   e_runs;
    logic         e_flush;
    logic [160:0] e_ops;
    if (started) begin
      e_pop   = !n_rst && !m_flush && (m_eng < 0) && !fifo_empty_i;
      e_runs  = (n_rst || m_eng < 0) ? 4'b0000 : 4'(1 << m_eng);
      e_flush = !n_rst && m_flush;
      e_ops   = n_rst ? '0 : ops_of(m_cmd);
      n_cmp++;
      if (pop_o !== e_pop) begin
        n_bad++;
        $display("FAIL pop @%0t: got %b expected %b", $time, pop_o, e_pop);
      end
      n_cmp++;
      if (dut_runs !== e_runs) begin
        n_bad++;
        $display("FAIL runs @%0t: got %b expected %b", $time, dut_runs, e_runs);
      end
      n_cmp++;
      if (flush_frame_o !== e_flush) begin
        n_bad++;
        $display("FAIL flush @%0t: got %b expected %b", $time, flush_frame_o, e_flush);
      end
      n_cmp++;
      if (dut_ops !== e_ops) begin
        n_bad++;
        $display("FAIL operands @%0t: got %h expected %h", $time, dut_ops, e_ops);
      end
    end
  end

  initial begin
    cmd_t c;
    logic [3:0] ops [3] = '{4'd1, 4'd2, 4'd3};
    logic [3:0] own [3] = '{4'b0001, 4'b0100, 4'b1000};
    logic [3:0] bad [3] = '{4'b0010, 4'b1000, 4'b0001};
    int rst_hold;

    junk = rand_cmd(4'b0100);
    drive_head();

    // Reset, then an empty FIFO showing FILL at its head must stay idle.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("rst_runs", 32'(dut_runs), 32'd0);
    check("rst_ops_x1", 32'(x1_fill_o), 32'd0);
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      check("empty_pop", 32'(pop_o), 32'd0);
      check("empty_runs", 32'(dut_runs), 32'd0);
    end

    // FILL 15/150/299/250, colour 10/9/8.
    c = rand_cmd(4'd4);
    c.x1 = 10'd15; c.y1 = 9'd150; c.x2 = 10'd299; c.y2 = 9'd250;
    c.r = 8'd10; c.g = 8'd9; c.b = 8'd8;
    fifo.push_back(c);
    step(4'b0000, 1'b0);
    check("fill_pop", 32'(pop_o), 32'd1);
    step(4'b0000, 1'b0);
    check("fill_pop_drop", 32'(pop_o), 32'd0);
    check("fill_runs", 32'(dut_runs), 32'b0010);
    check("fill_x1", 32'(x1_fill_o), 32'd15);
    check("fill_y1", 32'(y1_fill_o), 32'd150);
    check("fill_x2", 32'(x2_fill_o), 32'd299);
    check("fill_y2", 32'(y2_fill_o), 32'd250);
    check("fill_rgb", 32'({r_o, g_o, b_o}), 32'h0a0908);
    for (int i = 0; i < 10; i++) begin
      step(4'b1101, 1'b0);
      check("fill_hold", 32'(run_fill_o), 32'd1);
    end
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    check("fill_done_runs", 32'(dut_runs), 32'd0);
    check("fill_done_pop", 32'(pop_o), 32'd0);

    // LINE, ARC, CIRCLE: only their own finished ends the run.
    for (int k = 0; k < 3; k++) begin
      c = rand_cmd(ops[k]);
      if (k == 1) begin c.oct = 3'd5; c.rad = 10'd20; end
      fifo.push_back(c);
      step(4'b0000, 1'b0);
      check("eng_pop", 32'(pop_o), 32'd1);
      step(4'b0000, 1'b0);
      check("eng_runs", 32'(dut_runs), 32'(own[k]));
      if (k == 1) begin
        check("arc_oct", 32'(oct_arc_o), 32'd5);
        check("arc_rad", 32'(rad_arc_o), 32'd20);
      end
      step(bad[k], 1'b0);
      step(4'b0000, 1'b0);
      check("eng_wrong_fin", 32'(dut_runs), 32'(own[k]));
      step(own[k], 1'b0);
      step(4'b0000, 1'b0);
      check("eng_done", 32'(dut_runs), 32'd0);
    end

    // FLUSH strobe, then an illegal opcode that is dropped.
    fifo.push_back(rand_cmd(4'd5));
    step(4'b0000, 1'b0);
    check("flush_pop", 32'(pop_o), 32'd1);
    step(4'b0000, 1'b0);
    check("flush_hi", 32'(flush_frame_o), 32'd1);
    step(4'b0000, 1'b0);
    check("flush_lo", 32'(flush_frame_o), 32'd0);
    fifo.push_back(rand_cmd(4'hf));
    step(4'b0000, 1'b0);
    check("ill_pop", 32'(pop_o), 32'd1);
    step(4'b0000, 1'b0);
    check("ill_runs", 32'(dut_runs), 32'd0);
    check("ill_pop_after", 32'(pop_o), 32'd0);

    // Reset mid-RUN clears outputs immediately and discards the command.
    fifo.push_back(rand_cmd(4'd1));
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("mid_run", 32'(dut_runs), 32'b0001);
    fifo.push_back(rand_cmd(4'd4));
    n_rst = 1'b1;
    #1;
    check("arst_runs", 32'(dut_runs), 32'd0);
    check("arst_pop", 32'(pop_o), 32'd0);
    check("arst_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    step(4'b0001, 1'b0);
    check("arst_hold_pop", 32'(pop_o), 32'd0);
    n_rst = 1'b0;
    #1;
    check("post_rst_pop", 32'(pop_o), 32'd1);
    check("post_rst_runs", 32'(dut_runs), 32'd0);
    step(4'b0000, 1'b0);
    check("post_rst_fill", 32'(dut_runs), 32'b0010);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // Random traffic against the model.
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0)
        fifo.push_back(rand_cmd(($urandom_range(0, 7) < 6) ? 4'($urandom_range(0, 5)) : 4'($urandom)));
      junk = rand_cmd(4'($urandom));
      step({($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
           ($urandom_range(0, 7) == 0));
      if (rst_hold == 0 && $urandom_range(0, 399) == 0) begin
        n_rst = 1'b1;
        rst_hold = 2;
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) n_rst = 1'b0;
      end
    end
    n_rst = 1'b0;
    step(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
